// File: rtl/grant_lock_arbiter.sv
// Locking bus arbiter: one grant is held until done, requester drop or timeout,
// then a one-cycle release gap is enforced before the next arbitration.
module grant_lock_arbiter #(
  parameter int WIDTH       = 8,
  parameter int INDEX_WIDTH = 3,
  parameter int ROUND_ROBIN = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       request,
  input  logic                   done,
  output logic [WIDTH-1:0]       grant,
  output logic                   grantValid,
  output logic [INDEX_WIDTH-1:0] grantIndex,
  output logic                   timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [INDEX_WIDTH:0]   WIDTH_W    = (INDEX_WIDTH + 32'sd1)'(WIDTH);
  localparam logic [INDEX_WIDTH:0]   PROBE_ZERO = {(INDEX_WIDTH + 1){1'b0}};
  localparam logic [INDEX_WIDTH:0]   PROBE_ONE  = {{INDEX_WIDTH{1'b0}}, 1'b1};
  localparam logic [INDEX_WIDTH-1:0] INDEX_ZERO = {INDEX_WIDTH{1'b0}};
  localparam logic [INDEX_WIDTH-1:0] LAST_RESET = INDEX_WIDTH'(WIDTH - 32'sd1);
  localparam logic [15:0]            TIMEOUT_M1 = 16'(TIMEOUT - 32'sd1);
  localparam logic [WIDTH-1:0]       NO_GRANT   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]       ONE_HOT0   = {{(WIDTH - 1){1'b0}}, 1'b1};

  state_t                 state_r;
  logic [15:0]            count_r;
  logic [INDEX_WIDTH-1:0] last_index_r;
  logic [INDEX_WIDTH:0]   start_s;
  logic [INDEX_WIDTH:0]   probe_s;
  logic [INDEX_WIDTH-1:0] winner_s;
  logic                   release_s;

  // Search origin: bit 0 for fixed priority, one past the previous winner when rotating.
  always_comb begin
    start_s = PROBE_ZERO;
    if (ROUND_ROBIN != 32'sd0) begin
      start_s = {1'b0, last_index_r} + PROBE_ONE;
      start_s = (start_s >= WIDTH_W) ? (start_s - WIDTH_W) : start_s;
    end else begin
      start_s = PROBE_ZERO;
    end
  end

  // Scan in reverse search order so the earliest set bit is the last one written.
  always_comb begin
    winner_s = INDEX_ZERO;
    probe_s  = PROBE_ZERO;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      probe_s  = start_s + (INDEX_WIDTH + 32'sd1)'(k);
      probe_s  = (probe_s >= WIDTH_W) ? (probe_s - WIDTH_W) : probe_s;
      winner_s = request[probe_s[INDEX_WIDTH-1:0]] ? probe_s[INDEX_WIDTH-1:0] : winner_s;
    end
  end

  // A held grant ends when the slave finishes or the owner withdraws its request.
  always_comb begin
    release_s = done | ~request[grantIndex];
  end

  // Arbitration state machine; every output is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      grant        <= NO_GRANT;
      grantValid   <= 1'b0;
      grantIndex   <= INDEX_ZERO;
      timeout      <= 1'b0;
      count_r      <= 16'd0;
      last_index_r <= LAST_RESET;
    end else begin
      case (state_r)
        IDLE: begin
          timeout <= 1'b0;
          count_r <= 16'd0;
          if (|request) begin
            grant        <= ONE_HOT0 << winner_s;
            grantValid   <= 1'b1;
            grantIndex   <= winner_s;
            last_index_r <= winner_s;
            state_r      <= BUSY;
          end else begin
            grant      <= NO_GRANT;
            grantValid <= 1'b0;
            grantIndex <= INDEX_ZERO;
            state_r    <= IDLE;
          end
        end
        BUSY: begin
          if (release_s) begin
            // done wins over a timeout landing on the same cycle
            grant      <= NO_GRANT;
            grantValid <= 1'b0;
            grantIndex <= INDEX_ZERO;
            timeout    <= 1'b0;
            count_r    <= 16'd0;
            state_r    <= RELEASE;
          end else if (count_r == TIMEOUT_M1) begin
            grant      <= NO_GRANT;
            grantValid <= 1'b0;
            grantIndex <= INDEX_ZERO;
            timeout    <= 1'b1;
            count_r    <= 16'd0;
            state_r    <= RELEASE;
          end else begin
            timeout <= 1'b0;
            count_r <= count_r + 16'd1;
            state_r <= BUSY;
          end
        end
        RELEASE: begin
          grant      <= NO_GRANT;
          grantValid <= 1'b0;
          grantIndex <= INDEX_ZERO;
          timeout    <= 1'b0;
          count_r    <= 16'd0;
          state_r    <= IDLE;
        end
        default: begin
          grant      <= NO_GRANT;
          grantValid <= 1'b0;
          grantIndex <= INDEX_ZERO;
          timeout    <= 1'b0;
          count_r    <= 16'd0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grant_lock_arbiter.sv
// Self-checking bench: fixed-priority and rotating instances (TIMEOUT=4) share inputs
// and are compared every cycle against a behavioural arbitration model.
module tb_grant_lock_arbiter;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] request;
  logic       done;
  logic [7:0] grant0, grant1;
  logic       valid0, valid1;
  logic [2:0] index0, index1;
  logic       tout0, tout1;

  int tests = 0;
  int fails = 0;

  // model: current owner (-1 none), busy cycles elapsed, release gap, last winner, timeout pulse
  int m_owner [2];
  int m_held  [2];
  int m_last  [2];
  bit m_gap   [2];
  bit m_tout  [2];

  int rr_exp [4] = '{0, 1, 7, 0};

  always #5 clk = ~clk;

  grant_lock_arbiter #(.WIDTH(8), .INDEX_WIDTH(3), .ROUND_ROBIN(0), .TIMEOUT(TMO)) dut_fp (
    .clk(clk), .reset(reset), .request(request), .done(done),
    .grant(grant0), .grantValid(valid0), .grantIndex(index0), .timeout(tout0)
  );

  grant_lock_arbiter #(.WIDTH(8), .INDEX_WIDTH(3), .ROUND_ROBIN(1), .TIMEOUT(TMO)) dut_rr (
    .clk(clk), .reset(reset), .request(request), .done(done),
    .grant(grant1), .grantValid(valid1), .grantIndex(index1), .timeout(tout1)
  );

  function automatic int pick(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [7:0] r, input logic d, input logic rs);
    int w;
    for (int m = 0; m < 2; m++) begin
      m_tout[m] = 1'b0;
      if (rs) begin
        m_owner[m] = -1; m_held[m] = 0; m_gap[m] = 1'b0; m_last[m] = 7;
      end else if (m_owner[m] >= 0) begin
        if (d || !r[m_owner[m]]) begin
          m_owner[m] = -1; m_gap[m] = 1'b1;
        end else if (m_held[m] + 1 == TMO) begin
          m_owner[m] = -1; m_gap[m] = 1'b1; m_tout[m] = 1'b1;
        end else begin
          m_held[m]++;
        end
      end else if (m_gap[m]) begin
        m_gap[m] = 1'b0;
      end else if (r != 8'd0) begin
        w = pick(r, (m == 1) ? (m_last[m] + 1) % 8 : 0);
        m_owner[m] = w; m_last[m] = w; m_held[m] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_one(input string p, input int m, input logic [7:0] g, input logic v,
                           input logic [2:0] i, input logic t);
    logic [7:0] eg;
    eg = (m_owner[m] >= 0) ? (8'd1 << m_owner[m]) : 8'd0;
    chk({p, "_grant"}, 32'(g), 32'(eg));
    chk({p, "_valid"}, 32'(v), (m_owner[m] >= 0) ? 32'd1 : 32'd0);
    chk({p, "_index"}, 32'(i), (m_owner[m] >= 0) ? 32'(m_owner[m]) : 32'd0);
    chk({p, "_timeout"}, 32'(t), 32'(m_tout[m]));
    chk({p, "_onehot"}, 32'((g & (g - 8'd1)) == 8'd0), 32'd1);
    chk({p, "_valid_eq_nonzero"}, 32'(v), 32'(g != 8'd0));
  endtask

  task automatic tick(input logic [7:0] r, input logic d, input logic rs);
    request = r; done = d; reset = rs;
    @(posedge clk);
    model_step(r, d, rs);
    #1;
    check_one("fp", 0, grant0, valid0, index0, tout0);
    check_one("rr", 1, grant1, valid1, index1, tout1);
  endtask

  initial begin
    logic [7:0] r;
    logic       d, rs;
    for (int m = 0; m < 2; m++) begin
      m_owner[m] = -1; m_held[m] = 0; m_last[m] = 7; m_gap[m] = 1'b0; m_tout[m] = 1'b0;
    end
    request = 8'd0; done = 1'b0; reset = 1'b1;

    // reset state
    tick(8'h00, 1'b0, 1'b1);
    tick(8'h00, 1'b0, 1'b1);
    chk("reset_grant", 32'(grant0), 32'd0);
    chk("reset_valid", 32'(valid0), 32'd0);
    tick(8'h00, 1'b0, 1'b0);
    chk("idle_zero", 32'(grant0), 32'd0);

    // lowest-index winner, lock held while other bits change
    tick(8'b00110100, 1'b0, 1'b0);
    chk("fp_first_grant", 32'(grant0), 32'h04);
    chk("fp_first_index", 32'(index0), 32'd2);
    chk("fp_first_valid", 32'(valid0), 32'd1);
    tick(8'b00111100, 1'b0, 1'b0);
    chk("fp_lock_hold", 32'(grant0), 32'h04);
    tick(8'b11110101, 1'b0, 1'b0);
    chk("fp_lock_hold2", 32'(grant0), 32'h04);
    tick(8'b00110000, 1'b0, 1'b0);
    chk("fp_drop_release", 32'(grant0), 32'h00);

    // done pulse, release gap, regrant
    tick(8'b00000011, 1'b0, 1'b0);
    tick(8'b00000011, 1'b0, 1'b0);
    chk("done_setup", 32'(grant0), 32'h01);
    tick(8'b00000011, 1'b1, 1'b0);
    chk("done_release", 32'(grant0), 32'h00);
    tick(8'b00000011, 1'b0, 1'b0);
    chk("done_idle_gap", 32'(grant0), 32'h00);
    tick(8'b00000011, 1'b0, 1'b0);
    chk("done_regrant", 32'(grant0), 32'h01);
    tick(8'h00, 1'b1, 1'b0);
    tick(8'h00, 1'b1, 1'b0);

    // rotating priority sequence
    tick(8'h00, 1'b0, 1'b1);
    for (int n = 0; n < 4; n++) begin
      tick(8'b10000011, 1'b0, 1'b0);
      chk("rr_sequence", 32'(index1), 32'(rr_exp[n]));
      tick(8'b10000011, 1'b1, 1'b0);
      tick(8'b10000011, 1'b0, 1'b0);
    end

    // timeout after TMO busy cycles, then done on the timeout cycle
    tick(8'h00, 1'b0, 1'b1);
    tick(8'b00100000, 1'b0, 1'b0);
    chk("tmo_grant", 32'(grant0), 32'h20);
    for (int n = 1; n < TMO; n++) begin
      tick(8'b00100000, 1'b0, 1'b0);
      chk("tmo_hold", 32'(grant0), 32'h20);
      chk("tmo_quiet", 32'(tout0), 32'd0);
    end
    tick(8'b00100000, 1'b0, 1'b0);
    chk("tmo_cleared", 32'(grant0), 32'h00);
    chk("tmo_pulse", 32'(tout0), 32'd1);
    tick(8'b00100000, 1'b0, 1'b0);
    chk("tmo_pulse_end", 32'(tout0), 32'd0);
    tick(8'b00100000, 1'b0, 1'b0);
    chk("tmo_regrant", 32'(grant0), 32'h20);
    for (int n = 1; n < TMO; n++) tick(8'b00100000, 1'b0, 1'b0);
    tick(8'b00100000, 1'b1, 1'b0);
    chk("tmo_done_wins_grant", 32'(grant0), 32'h00);
    chk("tmo_done_wins_pulse", 32'(tout0), 32'd0);

    // reset during busy
    tick(8'b00100000, 1'b0, 1'b0);
    tick(8'b00100000, 1'b0, 1'b0);
    chk("rst_busy_setup", 32'(grant0), 32'h20);
    tick(8'b00100000, 1'b0, 1'b1);
    chk("rst_busy_grant", 32'(grant0), 32'h00);
    chk("rst_busy_index", 32'(index0), 32'd0);
    tick(8'b11100000, 1'b0, 1'b0);
    chk("rst_first_fp", 32'(grant0), 32'h20);
    chk("rst_first_rr", 32'(grant1), 32'h20);

    // randomized traffic against the model
    r = 8'h00;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = 8'($urandom);
        if ($urandom_range(0, 1) == 0) r = r & 8'($urandom);
      end
      d  = ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 99) == 0);
      tick(r, d, rs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
